mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 1-bit, 4:1 multiplexed channel among four requesters.

---
 rtl/mux_rr_arbiter_pkg.sv | 40 ++++
 rtl/mux_rr_arbiter_mux.sv | 13 +
 rtl/mux_rr_arbiter.sv | 99 +++++++++
 tb/tb_mux_rr_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state codes and the
// rotating priority pick used to choose the next channel owner.
package mux_rr_arbiter_pkg;

  // Arbiter state codes, kept as plain constants for compatibility with
  // the legacy include they replace.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Result of a round-robin search.
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Rotate req so that bit ptr lands at position 0, take the lowest set bit,
  // then map the winner back to its absolute requester index.
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [7:0] dbl;
    logic [3:0] rot;
    pick_t      res;
    dbl = {req, req} >> ptr;
    rot = dbl[3:0];
    res = '0;
    // Scan from the far end down so the bit closest to ptr wins.
    for (int unsigned k = 4; k > 0; k--) begin
      if (rot[k-1]) begin
        res.found = 1'b1;
        res.idx   = ptr + 2'(k - 1);
      end
    end
    return res;
  endfunction

  // One-hot grant vector for an owner index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Existing 4:1 single-bit multiplexer; the arbiter drives its select.
module DUT_multiplexer (
  input  logic [3:0] i,
  input  logic [1:0] s,
  output logic       out
);

  // Pass through the selected input bit.
  always_comb begin
    out = i[s];
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 1-bit 4:1 mux channel among four
// requesters. An owner keeps the channel for at most BURST_LEN cycles or
// until it drops its request; the next owner is then searched starting one
// past the previous owner, with no idle cycle between owners.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       out,
  output logic       out_valid
);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       gnt_q,   gnt_d;
  logic [1:0]       s_q,     s_d;

  pick_t            pick;
  logic             release_own;

  // Next-state logic: idle arbitration, burst counting and handover.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    s_d         = s_q;
    pick        = '0;
    release_own = 1'b0;

    if (state_q == ST_IDLE) begin
      pick = rr_pick(req, ptr_q);
      if (pick.found) begin
        state_d = ST_GRANT;
        s_d     = pick.idx;
        gnt_d   = onehot4(pick.idx);
        cnt_d   = '0;
      end
    end else begin
      release_own = ~req[s_q] | (cnt_q == CNT_W'(BURST_LEN - 1));
      if (!release_own) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        // Pointer advance and re-arbitration share one edge: the search uses
        // the advanced pointer so the outgoing owner is considered last.
        ptr_d = s_q + 2'd1;
        pick  = rr_pick(req, s_q + 2'd1);
        cnt_d = '0;
        if (pick.found) begin
          s_d   = pick.idx;
          gnt_d = onehot4(pick.idx);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
    end
  end

  // Channel is valid only while an owner holds it and still requests.
  always_comb begin
    gnt       = gnt_q;
    s         = s_q;
    out_valid = (state_q == ST_GRANT) & req[s_q];
  end

  DUT_multiplexer u_mux (
    .i   (i),
    .s   (s),
    .out (out)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one instance with BURST_LEN=4 and one
// with BURST_LEN=1 sharing clock and reset.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req  = 4'b0000;
  logic [3:0] i    = 4'b0000;
  logic [3:0] req1 = 4'b0000;
  logic [3:0] i1   = 4'b0000;

  logic [3:0] gnt,  gnt1;
  logic [1:0] s,    s1;
  logic       out,  out1;
  logic       ov,   ov1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(gnt), .s(s), .out(out), .out_valid(ov)
  );

  mux_rr_arbiter #(.BURST_LEN(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .i(i1),
    .gnt(gnt1), .s(s1), .out(out1), .out_valid(ov1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0] own;
    logic [3:0] exp_g;

    // 1: asynchronous reset with all requests high, before any clock edge.
    req  = 4'b1111;
    req1 = 4'b1111;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", {4'b0, gnt}, 8'h00);
    chk("rst_s", {6'b0, s}, 8'h00);
    chk("rst_ov", {7'b0, ov}, 8'h00);
    chk("rst_gnt1", {4'b0, gnt1}, 8'h00);
    chk("rst_ov1", {7'b0, ov1}, 8'h00);
    tick();
    chk("rst_hold_gnt", {4'b0, gnt}, 8'h00);
    req1 = 4'b0000;

    // 2: single requester 2 held 10 cycles; i[2] toggles, others opposite.
    req = 4'b0100;
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      i = k[0] ? 4'b0100 : 4'b1011;
      #1;
      chk("solo_gnt", {4'b0, gnt}, 8'h04);
      chk("solo_s", {6'b0, s}, 8'h02);
      chk("solo_ov", {7'b0, ov}, 8'h01);
      chk("solo_out", {7'b0, out}, {7'b0, k[0]});
    end

    // 3: all request; rotation 0,1,2,3,0 with 4 cycles each.
    pulse_rst();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      own   = 2'((k / 4) % 4);
      exp_g = 4'b0001 << own;
      i     = ~exp_g;
      if (k[0]) i = exp_g;
      #1;
      chk("rr_gnt", {4'b0, gnt}, {4'b0, exp_g});
      chk("rr_s", {6'b0, s}, {6'b0, own});
      chk("rr_ov", {7'b0, ov}, 8'h01);
      chk("rr_out", {7'b0, out}, {7'b0, k[0]});
    end

    // 4: owner 1 drops at burst cycle 2; req[3] waiting, no preemption before.
    pulse_rst();
    req = 4'b1010;
    tick();
    chk("drop_c0_gnt", {4'b0, gnt}, 8'h02);
    tick();
    chk("drop_c1_gnt", {4'b0, gnt}, 8'h02);
    tick();
    req = 4'b1000;
    #1;
    chk("drop_ov", {7'b0, ov}, 8'h00);
    chk("drop_c2_gnt", {4'b0, gnt}, 8'h02);
    tick();
    chk("hand_gnt", {4'b0, gnt}, 8'h08);
    chk("hand_s", {6'b0, s}, 8'h03);
    chk("hand_ov", {7'b0, ov}, 8'h01);

    // 5: advance ptr to 2 (owner 1 -> 2), reset mid-burst, restart from ptr 0.
    pulse_rst();
    req = 4'b0110;
    tick();
    chk("pre_gnt", {4'b0, gnt}, 8'h02);
    req = 4'b0100;
    tick();
    chk("mid_gnt", {4'b0, gnt}, 8'h04);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_gnt", {4'b0, gnt}, 8'h00);
    chk("arst_s", {6'b0, s}, 8'h00);
    chk("arst_ov", {7'b0, ov}, 8'h00);
    req = 4'b0110;
    #1 rst = 1'b0;
    tick();
    chk("post_gnt", {4'b0, gnt}, 8'h02);
    chk("post_s", {6'b0, s}, 8'h01);

    // 6: BURST_LEN=1 alternation between 0 and 2, then idle.
    req1 = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("b1_gnt", {4'b0, gnt1}, k[0] ? 8'h04 : 8'h01);
      chk("b1_ov", {7'b0, ov1}, 8'h01);
    end
    req1 = 4'b0000;
    #1;
    chk("b1_drop_ov", {7'b0, ov1}, 8'h00);
    tick();
    chk("b1_idle_gnt", {4'b0, gnt1}, 8'h00);
    chk("b1_idle_s", {6'b0, s1}, 8'h02);
    chk("b1_idle_ov", {7'b0, ov1}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
